interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer for a 6502-style core.
// Sequences RESET, BRK, NMI and IRQ entry: three stack steps (pushes are
// suppressed for RESET), then a two-byte vector fetch that also sets the I flag.
// NMI is edge-latched; IRQ is level-sensitive and masked by the I flag.
module interrupt_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        psr_i,
    input  logic        brk_req,
    input  logic        instr_boundary,
    input  logic        ready,
    output logic        busy,
    output logic        push_pch,
    output logic        push_pcl,
    output logic        push_p,
    output logic        sp_dec,
    output logic        b_flag_out,
    output logic        vec_lo_rd,
    output logic        vec_hi_rd,
    output logic [15:0] vector_addr,
    output logic        manual_set,
    output logic        manual_I,
    output logic        nmi_ack,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_RST_START = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PUSH_PCH  = 3'd2,
        ST_PUSH_PCL  = 3'd3,
        ST_PUSH_P    = 3'd4,
        ST_FETCH_LO  = 3'd5,
        ST_FETCH_HI  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_BRK   = 2'd1,
        SRC_NMI   = 2'd2,
        SRC_IRQ   = 2'd3
    } src_t;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    state_t      state_r;
    src_t        src_r;
    logic [15:0] vector_r;
    logic        nmi_s1_r;
    logic        nmi_s2_r;
    logic        irq_s1_r;
    logic        irq_s2_r;
    logic        nmi_pending_r;

    logic        nmi_fall_s;
    logic        irq_active_s;
    logic        vec_step_s;
    logic [15:0] sel_vector_s;

    // Two-flop synchronizers for the asynchronous interrupt pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_s1_r <= 1'b1;
            nmi_s2_r <= 1'b1;
            irq_s1_r <= 1'b1;
            irq_s2_r <= 1'b1;
        end else begin
            nmi_s1_r <= nmi_n;
            nmi_s2_r <= nmi_s1_r;
            irq_s1_r <= irq_n;
            irq_s2_r <= irq_s1_r;
        end
    end

    // The synchronized NMI is about to go 1->0 when the second stage is high
    // and the first stage has already captured low; pending is set on that edge.
    assign nmi_fall_s   = nmi_s2_r & ~nmi_s1_r;
    assign irq_active_s = ~irq_s2_r & ~psr_i;
    assign vec_step_s   = (state_r == ST_PUSH_P) && ready;

    // Vector choice at the status-push step; a pending NMI hijacks BRK and IRQ.
    always_comb begin
        sel_vector_s = VEC_IRQ;
        case (src_r)
            SRC_RESET: sel_vector_s = VEC_RESET;
            SRC_NMI:   sel_vector_s = VEC_NMI;
            SRC_BRK,
            SRC_IRQ: begin
                if (nmi_pending_r) begin
                    sel_vector_s = VEC_NMI;
                end else begin
                    sel_vector_s = VEC_IRQ;
                end
            end
            default:   sel_vector_s = VEC_IRQ;
        endcase
    end

    // NMI pending latch: a new edge outranks the acknowledge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_pending_r <= 1'b0;
        end else if (nmi_fall_s) begin
            nmi_pending_r <= 1'b1;
        end else if (nmi_ack) begin
            nmi_pending_r <= 1'b0;
        end else begin
            nmi_pending_r <= nmi_pending_r;
        end
    end

    // Sequencer state, captured source and latched vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RST_START;
            src_r    <= SRC_RESET;
            vector_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_RST_START: begin
                    state_r <= ST_PUSH_PCH;
                    src_r   <= SRC_RESET;
                end
                ST_IDLE: begin
                    if (instr_boundary && ready) begin
                        if (brk_req) begin
                            state_r <= ST_PUSH_PCH;
                            src_r   <= SRC_BRK;
                        end else if (nmi_pending_r) begin
                            state_r <= ST_PUSH_PCH;
                            src_r   <= SRC_NMI;
                        end else if (irq_active_s) begin
                            state_r <= ST_PUSH_PCH;
                            src_r   <= SRC_IRQ;
                        end
                    end
                end
                ST_PUSH_PCH: begin
                    if (ready) begin
                        state_r <= ST_PUSH_PCL;
                    end
                end
                ST_PUSH_PCL: begin
                    if (ready) begin
                        state_r <= ST_PUSH_P;
                    end
                end
                ST_PUSH_P: begin
                    if (ready) begin
                        state_r  <= ST_FETCH_LO;
                        vector_r <= sel_vector_s;
                    end
                end
                ST_FETCH_LO: begin
                    if (ready) begin
                        state_r <= ST_FETCH_HI;
                    end
                end
                ST_FETCH_HI: begin
                    if (ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from state; strobes only fire while the CPU is ready.
    always_comb begin
        busy        = 1'b0;
        push_pch    = 1'b0;
        push_pcl    = 1'b0;
        push_p      = 1'b0;
        sp_dec      = 1'b0;
        b_flag_out  = 1'b0;
        vec_lo_rd   = 1'b0;
        vec_hi_rd   = 1'b0;
        vector_addr = 16'h0000;
        manual_set  = 1'b0;
        manual_I    = 1'b0;
        nmi_ack     = 1'b0;
        done        = 1'b0;
        case (state_r)
            ST_RST_START: busy = 1'b0;
            ST_IDLE:      busy = 1'b0;
            ST_PUSH_PCH: begin
                busy     = 1'b1;
                push_pch = ready && (src_r != SRC_RESET);
                sp_dec   = ready;
            end
            ST_PUSH_PCL: begin
                busy     = 1'b1;
                push_pcl = ready && (src_r != SRC_RESET);
                sp_dec   = ready;
            end
            ST_PUSH_P: begin
                busy       = 1'b1;
                push_p     = ready && (src_r != SRC_RESET);
                sp_dec     = ready;
                b_flag_out = ready && (src_r == SRC_BRK);
                nmi_ack    = vec_step_s && (sel_vector_s == VEC_NMI);
            end
            ST_FETCH_LO: begin
                busy        = 1'b1;
                vec_lo_rd   = ready;
                manual_set  = ready;
                manual_I    = ready;
                vector_addr = vector_r;
            end
            ST_FETCH_HI: begin
                busy        = 1'b1;
                vec_hi_rd   = ready;
                done        = ready;
                vector_addr = vector_r + 16'd1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed testbench for interrupt_sequencer: each task walks one scenario
// cycle by cycle against hand-computed output tables.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        psr_i = 1'b1;
    logic        brk_req = 1'b0;
    logic        instr_boundary = 1'b0;
    logic        ready = 1'b1;
    logic        busy, push_pch, push_pcl, push_p, sp_dec, b_flag_out;
    logic        vec_lo_rd, vec_hi_rd, manual_set, manual_I, nmi_ack, done;
    logic [15:0] vector_addr;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] O_BUSY = 12'h800;
    localparam logic [11:0] O_PH   = 12'h400;
    localparam logic [11:0] O_PL   = 12'h200;
    localparam logic [11:0] O_PP   = 12'h100;
    localparam logic [11:0] O_SD   = 12'h080;
    localparam logic [11:0] O_BF   = 12'h040;
    localparam logic [11:0] O_VL   = 12'h020;
    localparam logic [11:0] O_VH   = 12'h010;
    localparam logic [11:0] O_MS   = 12'h008;
    localparam logic [11:0] O_MI   = 12'h004;
    localparam logic [11:0] O_NA   = 12'h002;
    localparam logic [11:0] O_DN   = 12'h001;

    logic [11:0] obs;
    assign obs = {busy, push_pch, push_pcl, push_p, sp_dec, b_flag_out,
                  vec_lo_rd, vec_hi_rd, manual_set, manual_I, nmi_ack, done};

    interrupt_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .psr_i          (psr_i),
        .brk_req        (brk_req),
        .instr_boundary (instr_boundary),
        .ready          (ready),
        .busy           (busy),
        .push_pch       (push_pch),
        .push_pcl       (push_pcl),
        .push_p         (push_p),
        .sp_dec         (sp_dec),
        .b_flag_out     (b_flag_out),
        .vec_lo_rd      (vec_lo_rd),
        .vec_hi_rd      (vec_hi_rd),
        .vector_addr    (vector_addr),
        .manual_set     (manual_set),
        .manual_I       (manual_I),
        .nmi_ack        (nmi_ack),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full RESET entry sequence right after rst is released.
    task automatic test_reset;
        logic [11:0] eo [0:5];
        logic [15:0] ea [0:5];
        eo[0] = O_BUSY | O_SD;               ea[0] = 16'h0000;
        eo[1] = O_BUSY | O_SD;               ea[1] = 16'h0000;
        eo[2] = O_BUSY | O_SD;               ea[2] = 16'h0000;
        eo[3] = O_BUSY | O_VL | O_MS | O_MI; ea[3] = 16'hFFFC;
        eo[4] = O_BUSY | O_VH | O_DN;        ea[4] = 16'hFFFD;
        eo[5] = 12'h000;                     ea[5] = 16'h0000;
        rst = 1'b1;
        wait_cycles(2);
        total++;
        if (obs !== 12'h000 || vector_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold got=%h/%h want=000/0000", obs, vector_addr);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            total++;
            if (obs !== eo[i] || vector_addr !== ea[i]) begin
                bad++;
                $display("FAIL reset_seq cyc%0d got=%h/%h want=%h/%h",
                         i, obs, vector_addr, eo[i], ea[i]);
            end
        end
    endtask

    // Unmasked IRQ sequence, then masked IRQ must leave the sequencer idle.
    task automatic test_irq;
        logic [11:0] eo [0:5];
        logic [15:0] ea [0:5];
        eo[0] = O_BUSY | O_PH | O_SD;        ea[0] = 16'h0000;
        eo[1] = O_BUSY | O_PL | O_SD;        ea[1] = 16'h0000;
        eo[2] = O_BUSY | O_PP | O_SD;        ea[2] = 16'h0000;
        eo[3] = O_BUSY | O_VL | O_MS | O_MI; ea[3] = 16'hFFFE;
        eo[4] = O_BUSY | O_VH | O_DN;        ea[4] = 16'hFFFF;
        eo[5] = 12'h000;                     ea[5] = 16'h0000;
        irq_n = 1'b0;
        psr_i = 1'b0;
        wait_cycles(3);
        instr_boundary = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            #1;
            total++;
            if (obs !== eo[i] || vector_addr !== ea[i]) begin
                bad++;
                $display("FAIL irq_seq cyc%0d got=%h/%h want=%h/%h",
                         i, obs, vector_addr, eo[i], ea[i]);
            end
        end
        psr_i = 1'b1;
        wait_cycles(1);
        instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            #1;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL irq_masked cyc%0d busy got=%b want=0", i, busy);
            end
        end
        irq_n = 1'b1;
        wait_cycles(3);
    endtask

    // BRK with an NMI edge arriving mid-sequence: NMI vector hijacks, B stays 1.
    task automatic test_brk_hijack;
        logic [11:0] eo [0:5];
        logic [15:0] ea [0:5];
        eo[0] = O_BUSY | O_PH | O_SD;                ea[0] = 16'h0000;
        eo[1] = O_BUSY | O_PL | O_SD;                ea[1] = 16'h0000;
        eo[2] = O_BUSY | O_PP | O_SD | O_BF | O_NA;  ea[2] = 16'h0000;
        eo[3] = O_BUSY | O_VL | O_MS | O_MI;         ea[3] = 16'hFFFA;
        eo[4] = O_BUSY | O_VH | O_DN;                ea[4] = 16'hFFFB;
        eo[5] = 12'h000;                             ea[5] = 16'h0000;
        instr_boundary = 1'b1;
        brk_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            brk_req = 1'b0;
            if (i == 0) nmi_n = 1'b0;
            #1;
            total++;
            if (obs !== eo[i] || vector_addr !== ea[i]) begin
                bad++;
                $display("FAIL brk_hijack cyc%0d got=%h/%h want=%h/%h",
                         i, obs, vector_addr, eo[i], ea[i]);
            end
        end
        // NMI was consumed by the hijack; held-low pin must not start another.
        instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            #1;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL brk_nmi_consumed cyc%0d busy got=%b want=0", i, busy);
            end
        end
    endtask

    // One NMI entry from a fresh high-then-low edge on the pin.
    task automatic test_nmi_edge(input int pass);
        logic [11:0] eo [0:5];
        logic [15:0] ea [0:5];
        eo[0] = O_BUSY | O_PH | O_SD;         ea[0] = 16'h0000;
        eo[1] = O_BUSY | O_PL | O_SD;         ea[1] = 16'h0000;
        eo[2] = O_BUSY | O_PP | O_SD | O_NA;  ea[2] = 16'h0000;
        eo[3] = O_BUSY | O_VL | O_MS | O_MI;  ea[3] = 16'hFFFA;
        eo[4] = O_BUSY | O_VH | O_DN;         ea[4] = 16'hFFFB;
        eo[5] = 12'h000;                      ea[5] = 16'h0000;
        nmi_n = 1'b1;
        wait_cycles(3);
        nmi_n = 1'b0;
        wait_cycles(3);
        instr_boundary = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            #1;
            total++;
            if (obs !== eo[i] || vector_addr !== ea[i]) begin
                bad++;
                $display("FAIL nmi_seq p%0d cyc%0d got=%h/%h want=%h/%h",
                         pass, i, obs, vector_addr, eo[i], ea[i]);
            end
        end
        instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            #1;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL nmi_once p%0d cyc%0d busy got=%b want=0", pass, i, busy);
            end
        end
    endtask

    // IRQ sequence with ready low for three cycles in PUSH_PCL.
    task automatic test_ready_stall;
        logic [11:0] eo [0:8];
        logic [15:0] ea [0:8];
        eo[0] = O_BUSY | O_PH | O_SD;        ea[0] = 16'h0000;
        eo[1] = O_BUSY;                      ea[1] = 16'h0000;
        eo[2] = O_BUSY;                      ea[2] = 16'h0000;
        eo[3] = O_BUSY;                      ea[3] = 16'h0000;
        eo[4] = O_BUSY | O_PL | O_SD;        ea[4] = 16'h0000;
        eo[5] = O_BUSY | O_PP | O_SD;        ea[5] = 16'h0000;
        eo[6] = O_BUSY | O_VL | O_MS | O_MI; ea[6] = 16'hFFFE;
        eo[7] = O_BUSY | O_VH | O_DN;        ea[7] = 16'hFFFF;
        eo[8] = 12'h000;                     ea[8] = 16'h0000;
        irq_n = 1'b0;
        psr_i = 1'b0;
        wait_cycles(3);
        instr_boundary = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            ready = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            #1;
            total++;
            if (obs !== eo[i] || vector_addr !== ea[i]) begin
                bad++;
                $display("FAIL ready_stall cyc%0d got=%h/%h want=%h/%h",
                         i, obs, vector_addr, eo[i], ea[i]);
            end
        end
        ready = 1'b1;
        irq_n = 1'b1;
        psr_i = 1'b1;
        wait_cycles(3);
    endtask

    // Reset hitting FETCH_LO of a BRK sequence aborts it, then RESET re-runs.
    task automatic test_reset_mid;
        logic [11:0] eo [0:3];
        logic [15:0] ea [0:3];
        eo[0] = O_BUSY | O_PH | O_SD;          ea[0] = 16'h0000;
        eo[1] = O_BUSY | O_PL | O_SD;          ea[1] = 16'h0000;
        eo[2] = O_BUSY | O_PP | O_SD | O_BF;   ea[2] = 16'h0000;
        eo[3] = O_BUSY | O_VL | O_MS | O_MI;   ea[3] = 16'hFFFE;
        instr_boundary = 1'b1;
        brk_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            instr_boundary = 1'b0;
            brk_req = 1'b0;
            #1;
            total++;
            if (obs !== eo[i] || vector_addr !== ea[i]) begin
                bad++;
                $display("FAIL brk_pre_reset cyc%0d got=%h/%h want=%h/%h",
                         i, obs, vector_addr, eo[i], ea[i]);
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 12'h000 || vector_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_abort got=%h/%h want=000/0000", obs, vector_addr);
        end
        wait_cycles(1);
        total++;
        if (obs !== 12'h000 || vector_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_abort_hold got=%h/%h want=000/0000", obs, vector_addr);
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_irq();
        test_brk_hijack();
        test_nmi_edge(1);
        test_nmi_edge(2);
        test_ready_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
